// File: rtl/regfile_access_master_if.sv
// Command/response channel and single-port register-file bus of regfile_access_master.
// The master modport is the initiator's view; slave is the command source plus register file.
interface regfile_access_master_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned RBITS = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [RBITS-1:0] cmd_rd;
    logic [RBITS-1:0] cmd_rs;
    logic [XLEN-1:0]  cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_data;
    logic [RBITS-1:0] rf_reg_num;
    logic             rf_write;
    logic [XLEN-1:0]  rf_wdata;
    logic [XLEN-1:0]  rf_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_data, rsp_ready, rf_rdata,
        output cmd_ready, rsp_valid, rsp_data, rf_reg_num, rf_write, rf_wdata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_data, rsp_ready, rf_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rf_reg_num, rf_write, rf_wdata
    );
endinterface

// File: rtl/regfile_access_master.sv
// Command-driven initiator for the single-port register file: turns READ/WRITE/COPY/ADD
// commands into sequenced read/write port cycles and returns one response per command.
module regfile_access_master #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned RBITS        = 5,
    parameter bit          X0_HARDWIRED = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetn,
    regfile_access_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,
        OP_ADD   = 2'b11
    } op_t;

    state_t           state;
    state_t           state_nxt;
    op_t              op_q;
    op_t              cmd_op;
    logic [RBITS-1:0] rd_q;
    logic [RBITS-1:0] reg_num_q;
    logic [XLEN-1:0]  data_q;
    logic [XLEN-1:0]  wdata_q;
    logic [XLEN-1:0]  rsp_data_q;

    logic             accept;
    logic             rd_suppress;
    logic             cmd_ready_c;
    logic             rsp_valid_c;
    logic             rf_write_c;
    logic [XLEN-1:0]  rd_value;
    logic [XLEN-1:0]  wr_value;

    assign cmd_op      = op_t'(bus.cmd_op);
    assign accept      = bus.cmd_valid && cmd_ready_c;
    assign rd_suppress = X0_HARDWIRED && (rd_q == '0);

    // During RD, reg_num_q holds rs; reg 0 reads as zero when hardwired
    assign rd_value = (X0_HARDWIRED && (reg_num_q == '0)) ? '0 : bus.rf_rdata;
    assign wr_value = (op_q == OP_ADD) ? rd_value + data_q : rd_value;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        rf_write_c  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = resetn;
                if (bus.cmd_valid && resetn) begin
                    state_nxt = (cmd_op == OP_WRITE) ? WR : RD;
                end
            end
            RD: begin
                state_nxt = (op_q == OP_READ) ? RESP : WR;
            end
            WR: begin
                rf_write_c = resetn && !rd_suppress;
                state_nxt  = RESP;
            end
            RESP: begin
                rsp_valid_c = resetn;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The read value is folded straight into the write-data register at the end of RD,
    // so no separate read latch is kept; WR then echoes that register as the response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q       <= OP_READ;
            rd_q       <= '0;
            data_q     <= '0;
            reg_num_q  <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        rd_q   <= bus.cmd_rd;
                        data_q <= bus.cmd_data;
                        if (cmd_op == OP_WRITE) begin
                            reg_num_q <= bus.cmd_rd;
                            wdata_q   <= bus.cmd_data;
                        end else begin
                            reg_num_q <= bus.cmd_rs;
                        end
                    end
                end
                RD: begin
                    if (op_q == OP_READ) begin
                        rsp_data_q <= rd_value;
                    end else begin
                        reg_num_q <= rd_q;
                        wdata_q   <= wr_value;
                    end
                end
                WR: begin
                    rsp_data_q <= rd_suppress ? '0 : wdata_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rf_write   = rf_write_c;
    assign bus.rf_reg_num = reg_num_q;
    assign bus.rf_wdata   = wdata_q;
    assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_regfile_access_master.sv
// Bench for regfile_access_master: register-file model, per-cycle timeline reference
// model with a compare process, directed cases with literal expectations, then random commands.
module tb_regfile_access_master;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned RBITS = 5;
    localparam int unsigned NREG  = 32;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    logic clk       = 1'b0;
    logic resetn    = 1'b0;
    logic load_init = 1'b1;
    int   n_checks  = 0;
    int   n_fails   = 0;

    regfile_access_master_if #(.XLEN(XLEN), .RBITS(RBITS)) bus ();

    regfile_access_master #(
        .XLEN(XLEN),
        .RBITS(RBITS),
        .X0_HARDWIRED(1'b1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Register file seen by the DUT; reg 0 holds a nonzero value the master must mask.
    logic [XLEN-1:0] rf_mem   [NREG];
    logic [XLEN-1:0] init_val [NREG];

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < NREG; i++) rf_mem[i] <= init_val[i];
        end else if (bus.rf_write) begin
            rf_mem[bus.rf_reg_num] <= bus.rf_wdata;
        end
    end

    always_comb bus.rf_rdata = rf_mem[bus.rf_reg_num];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic give_up(input string what);
        n_checks++;
        n_fails++;
        $display("FAIL %s: waited more than 20 cycles, required within 20", what);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "bench stopped");
    endtask

    // Reference: architectural register contents plus the timeline of the command in flight
    logic [XLEN-1:0]  mreg [NREG];
    bit               m_busy  = 1'b0;
    int               m_age   = 0;
    int               m_lat   = 0;
    bit               m_rdop  = 1'b0;
    bit               m_wrop  = 1'b0;
    bit               m_wren  = 1'b0;
    logic [RBITS-1:0] m_rs    = '0;
    logic [RBITS-1:0] m_rd    = '0;
    logic [XLEN-1:0]  m_val   = '0;
    logic [XLEN-1:0]  m_rsp   = '0;
    bit               rst_prev = 1'b0;

    always @(negedge clk) begin
        bit e_ready;
        bit e_rvalid;
        bit e_wcyc;
        logic [XLEN-1:0] rv;
        e_ready  = resetn && !m_busy;
        e_rvalid = resetn && m_busy && (m_age >= m_lat);
        e_wcyc   = resetn && m_busy && m_wrop && (m_age == m_lat - 1);

        chk("cmd_ready", 64'(bus.cmd_ready), 64'(e_ready));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rvalid));
        chk("rf_write", 64'(bus.rf_write), 64'(e_wcyc && m_wren));
        if (e_wcyc && m_wren) begin
            chk("rf_reg_num_wr", 64'(bus.rf_reg_num), 64'(m_rd));
            chk("rf_wdata", bus.rf_wdata, m_val);
        end
        if (resetn && m_busy && m_rdop && m_age == 1)
            chk("rf_reg_num_rd", 64'(bus.rf_reg_num), 64'(m_rs));
        if (e_rvalid) chk("rsp_data", bus.rsp_data, m_rsp);
        if (rst_prev) begin
            chk("reset_rsp_data", bus.rsp_data, '0);
            chk("reset_rf_reg_num", 64'(bus.rf_reg_num), '0);
            chk("reset_rf_wdata", bus.rf_wdata, '0);
        end

        if (load_init) begin
            for (int i = 0; i < NREG; i++) mreg[i] = init_val[i];
        end
        if (!resetn) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (e_wcyc && m_wren) mreg[m_rd] = m_val;
            if (e_rvalid && bus.rsp_ready) m_busy = 1'b0;
            else m_age++;
        end else if (bus.cmd_valid) begin
            m_rs = bus.cmd_rs;
            m_rd = bus.cmd_rd;
            rv   = (m_rs == '0) ? '0 : mreg[m_rs];
            case (bus.cmd_op)
                OP_READ:  begin m_lat = 2; m_rdop = 1'b1; m_wrop = 1'b0; m_val = rv; end
                OP_WRITE: begin m_lat = 2; m_rdop = 1'b0; m_wrop = 1'b1; m_val = bus.cmd_data; end
                OP_COPY:  begin m_lat = 3; m_rdop = 1'b1; m_wrop = 1'b1; m_val = rv; end
                default:  begin m_lat = 3; m_rdop = 1'b1; m_wrop = 1'b1; m_val = rv + bus.cmd_data; end
            endcase
            m_wren = m_wrop && (m_rd != '0);
            m_rsp  = !m_wrop ? rv : ((m_rd == '0) ? '0 : m_val);
            m_busy = 1'b1;
            m_age  = 1;
        end
        rst_prev = !resetn;
    end

    task automatic scramble();
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 2'($urandom);
        bus.cmd_rd    = RBITS'($urandom);
        bus.cmd_rs    = RBITS'($urandom);
        bus.cmd_data  = {$urandom, $urandom};
    endtask

    // Called just after a rising edge; returns just after a rising edge in an idle cycle.
    task automatic issue(input logic [1:0] op, input logic [RBITS-1:0] rd, input logic [RBITS-1:0] rs,
                         input logic [XLEN-1:0] d, input int hold,
                         output logic [XLEN-1:0] rsp, output int lat);
        int t;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs    = rs;
        bus.cmd_data  = d;
        bus.rsp_ready = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bus.cmd_ready) begin
            t++;
            if (t > 20) give_up("cmd_ready_wait");
            @(negedge clk);
        end
        lat = 0;
        rsp = '0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            scramble();
            @(negedge clk);
            if (bus.rsp_valid) lat = k;
        end
        if (lat == 0) give_up("rsp_valid_wait");
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            scramble();
            @(negedge clk);
        end
        @(posedge clk); #1;
        scramble();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rsp = bus.rsp_data;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    function automatic logic [RBITS-1:0] pick_reg();
        logic [RBITS-1:0] hot [4];
        hot[0] = 5'd0; hot[1] = 5'd5; hot[2] = 5'd6; hot[3] = 5'd7;
        if ($urandom_range(0, 3) == 0) return hot[$urandom_range(0, 3)];
        return RBITS'($urandom);
    endfunction

    initial begin
        logic [XLEN-1:0] r;
        int lat;
        int t;
        for (int i = 0; i < NREG; i++) init_val[i] = {$urandom, $urandom};
        init_val[0] = 64'hBEEF;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rs    = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn    = 1'b1;
        load_init = 1'b0;

        issue(OP_WRITE, 5'd5, 5'd0, 64'h1234, 0, r, lat);
        chk("t1_rsp", r, 64'h1234);
        chk("t1_lat", 64'(lat), 64'd2);
        chk("t1_reg5", rf_mem[5], 64'h1234);

        issue(OP_READ, 5'd0, 5'd5, 64'h0, 4, r, lat);
        chk("t2_rsp", r, 64'h1234);
        chk("t2_lat", 64'(lat), 64'd2);

        issue(OP_ADD, 5'd6, 5'd5, 64'hFFFF_FFFF_FFFF_EDCC, 1, r, lat);
        chk("t3_rsp", r, 64'h0);
        chk("t3_lat", 64'(lat), 64'd3);
        chk("t3_reg6", rf_mem[6], 64'h0);

        issue(OP_WRITE, 5'd0, 5'd0, 64'hDEAD, 0, r, lat);
        chk("t4_wr_rsp", r, 64'h0);
        chk("t4_reg0", rf_mem[0], 64'hBEEF);
        issue(OP_READ, 5'd0, 5'd0, 64'h0, 0, r, lat);
        chk("t4_rd_rsp", r, 64'h0);

        issue(OP_WRITE, 5'd7, 5'd0, 64'hA5, 0, r, lat);
        issue(OP_COPY, 5'd7, 5'd7, 64'h0, 2, r, lat);
        chk("t5_rsp", r, 64'hA5);
        chk("t5_lat", 64'(lat), 64'd3);
        chk("t5_reg7", rf_mem[7], 64'hA5);

        // ADD reg7+1 -> reg6, reset asserted during its write cycle
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_rd    = 5'd6;
        bus.cmd_rs    = 5'd7;
        bus.cmd_data  = 64'd1;
        t = 0;
        @(negedge clk);
        while (!bus.cmd_ready) begin
            t++;
            if (t > 20) give_up("t6_cmd_ready_wait");
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(negedge clk);
        chk("t6_abort_rf_write", 64'(bus.rf_write), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_ready_after_reset", 64'(bus.cmd_ready), 64'd1);
        chk("t6_no_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        chk("t6_reg6_untouched", rf_mem[6], 64'h0);

        repeat (250) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            issue(2'($urandom), pick_reg(), pick_reg(), {$urandom, $urandom},
                  int'($urandom_range(0, 3)), r, lat);
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < NREG; i++) chk($sformatf("final_reg%0d", i), rf_mem[i], mreg[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
